// File: rtl/fetch_sequencer_if.sv
// Fetch-control bundle between the fetch sequencer and the fetch/decode/execute stages.
// The master side is the sequencer; the slave side is the pipeline that raises requests.
interface fetch_sequencer_if #(
    parameter int DBITS = 32
);
    logic             stall_req;
    logic             br_taken;
    logic [DBITS-1:0] br_target;
    logic             exc_req;
    logic             resume;
    logic [DBITS-1:0] inst_word;
    logic             sel_pc;
    logic [DBITS-1:0] next_pc;
    logic             pc_stay;
    logic             flush;
    logic             halted;
    logic [15:0]      redirect_cnt;

    modport master (
        input  stall_req, br_taken, br_target, exc_req, resume, inst_word,
        output sel_pc, next_pc, pc_stay, flush, halted, redirect_cnt
    );

    modport slave (
        output stall_req, br_taken, br_target, exc_req, resume, inst_word,
        input  sel_pc, next_pc, pc_stay, flush, halted, redirect_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Arbitrates exception/branch redirects, load-use stalls and halt parking for the fetch PC.
// PC-select and flush outputs are combinational (zero redirect latency); halted/redirect_cnt are registered.
module fetch_sequencer #(
    parameter int                 DBITS        = 32,
    parameter logic [DBITS-1:0]   HALT_WORD    = 32'hdead,
    parameter logic [DBITS-1:0]   EXC_VECTOR   = 32'h20,
    parameter int                 FLUSH_CYCLES = 2
) (
    input logic                clk,
    input logic                reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       flush_cnt;
    logic [3:0]       flush_cnt_nxt;
    logic [15:0]      redirect_cnt;
    logic             redirect;
    logic             sel_pc;
    logic [DBITS-1:0] next_pc;
    logic             pc_stay;
    logic             flush;

    assign redirect = bus.exc_req | bus.br_taken;

    always_comb begin
        sel_pc        = 1'b0;
        next_pc       = '0;
        pc_stay       = 1'b0;
        flush         = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;

        if (reset) begin
            flush = 1'b1;
        end else if (redirect) begin
            // A redirect always wins: it comes from an older instruction than anything stalled or halted.
            sel_pc        = 1'b1;
            next_pc       = bus.exc_req ? EXC_VECTOR : bus.br_target;
            flush         = 1'b1;
            flush_cnt_nxt = FLUSH_LOAD;
            state_nxt     = MULTI_FLUSH ? FLUSH : RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.stall_req) begin
                        pc_stay = 1'b1;
                    end else if (bus.inst_word == HALT_WORD) begin
                        pc_stay   = 1'b1;
                        state_nxt = HALT;
                    end
                end
                FLUSH: begin
                    // The fetched word is being squashed, so stalls and halt words are meaningless here.
                    flush         = 1'b1;
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        state_nxt = RUN;
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        state_nxt = RUN;
                    end else begin
                        pc_stay = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            flush_cnt    <= 4'd0;
            redirect_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

    assign bus.sel_pc       = sel_pc;
    assign bus.next_pc      = next_pc;
    assign bus.pc_stay      = pc_stay;
    assign bus.flush        = flush;
    assign bus.halted       = (state == HALT) && !reset;
    assign bus.redirect_cnt = redirect_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer: one table row per clock cycle plus a saturation sequence.
module tb_fetch_sequencer;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_dead;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        exc;
        logic        res;
        logic [31:0] tgt;
        logic [31:0] inst;
        logic        sel;
        logic [31:0] npc;
        logic        stay;
        logic        fl;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    fetch_sequencer_if #(.DBITS(32)) bus ();

    fetch_sequencer #(
        .DBITS       (32),
        .HALT_WORD   (32'hdead),
        .EXC_VECTOR  (32'h20),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, stall, br, exc, res,
                                input logic [31:0] tgt, inst,
                                input logic sel, input logic [31:0] npc,
                                input logic stay, fl, hlt, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.exc = exc; v.res = res;
        v.tgt = tgt; v.inst = inst;
        v.sel = sel; v.npc = npc; v.stay = stay; v.fl = fl; v.hlt = hlt; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic rst, stall, br, exc, res, input logic [31:0] tgt, inst);
        reset         = rst;
        bus.stall_req = stall;
        bus.br_taken  = br;
        bus.exc_req   = exc;
        bus.resume    = res;
        bus.br_target = tgt;
        bus.inst_word = inst;
    endtask

    task automatic check(input string nm, input logic sel, input logic [31:0] npc,
                         input logic stay, fl, hlt, input logic [15:0] cnt);
        n_vec++;
        if (bus.sel_pc !== sel || bus.next_pc !== npc || bus.pc_stay !== stay ||
            bus.flush !== fl || bus.halted !== hlt || bus.redirect_cnt !== cnt) begin
            n_bad++;
            $display("FAIL %s: got sel=%b npc=%h stay=%b flush=%b halted=%b cnt=%h, want sel=%b npc=%h stay=%b flush=%b halted=%b cnt=%h",
                     nm, bus.sel_pc, bus.next_pc, bus.pc_stay, bus.flush, bus.halted, bus.redirect_cnt,
                     sel, npc, stay, fl, hlt, cnt);
        end
    endtask

    vec_t tbl[$];

    initial begin
        //                rst stl br exc res tgt           inst    sel npc           stay fl hlt cnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 1, 0, 16'd0));  // reset cycle
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h100,   NOP,  1, 32'h100,   0, 1, 0, 16'd0));  // branch
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 1, 0, 16'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 32'h200,   NOP,  1, 32'h20,    0, 1, 0, 16'd1));  // exc+br+stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 1, 0, 16'd2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     1, 0, 0, 16'd2));  // load-use stall
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 0, 16'd2));  // halt word seen
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, HALT, 0, 32'h0,     1, 0, 1, 16'd2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,     HALT, 0, 32'h0,     0, 0, 1, 16'd2));  // resume
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 1, 16'd2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h80,    HALT, 1, 32'h80,    0, 1, 1, 16'd2));  // branch out of HALT
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     0, 1, 0, 16'd3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h300,   NOP,  1, 32'h300,   0, 1, 0, 16'd3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h400,   NOP,  1, 32'h400,   0, 1, 0, 16'd4));  // branch inside FLUSH
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 1, 0, 16'd5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h500,   NOP,  1, 32'h500,   0, 1, 0, 16'd5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 1, 0, 16'd6));  // reset mid-FLUSH
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     0, 1, 0, 16'd0));  // reset mid-HALT
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     HALT, 0, 32'h0,     1, 0, 0, 16'd0));  // stall beats halt
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     NOP,  0, 32'h0,     0, 0, 0, 16'd0));

        drive(1, 0, 0, 0, 0, 32'h0, NOP);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].exc, tbl[i].res, tbl[i].tgt, tbl[i].inst);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].npc, tbl[i].stay, tbl[i].fl, tbl[i].hlt, tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        // Counter saturation: back-to-back redirects up to and past 16'hFFFF.
        drive(1, 0, 0, 0, 0, 32'h0, NOP);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0, 0, 32'h40, NOP);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_fffe", 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        check("sat_ffff", 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 32'h0, NOP);
        @(negedge clk);
        check("sat_hold", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check("sat_run", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
